evr_trigger_pulse_gen: RTL and testbench
========================================

Name: evr_trigger_pulse_gen

Overview:
- Downstream consumer of the EVR-synchronous generated clock strobe (evrClkGenStrobe, one evrClk tick per generated-clock rising edge).
- Produces a delayed, width-programmable trigger pulse in the evrClk domain for front-panel/diagnostic outputs.
- Keeps trigger and overrun statistics.
- Configuration inputs are already in the evrClk domain; CSR crossing is done elsewhere.

Parameters:
DELAY_WIDTH, 24, width of delayTicks (evrClk ticks)
WIDTH_WIDTH, 16, width of widthTicks (evrClk ticks)
COUNT_WIDTH, 16, width of triggerCount and overrunCount

Ports:
evrClk  in  1  EVR recovered clock; only clock
evrReset_n  in  1  synchronous, active-low reset
enable  in  1  block enable; low aborts any activity
requireSync  in  1  1: accept strobes only while evrClkGenSynced=1
evrClkGenSynced  in  1  generated clock locked to heartbeat
evrClkGenStrobe  in  1  single-tick strobe, generated-clock rising edge
delayTicks  in  DELAY_WIDTH  strobe-to-pulse delay
widthTicks  in  WIDTH_WIDTH  pulse width; 0 = pulse suppressed
overrunClear  in  1  single-tick clear of overrunCount
evrTrigger  out  1  registered trigger output
busy  out  1  state != IDLE
triggerCount  out  COUNT_WIDTH  pulses issued, wraps
overrunCount  out  COUNT_WIDTH  strobes dropped while busy, saturates

Behaviour:
- Reset (evrReset_n=0 at posedge): state=IDLE, evrTrigger=0, busy=0, counters=0, internal tick counter=0.
- Accept condition at cycle T: state IDLE, enable=1, evrClkGenStrobe=1, (requireSync=0 or evrClkGenSynced=1), widthTicks!=0.
- On accept, latch delayTicks (D) and widthTicks (W). Later changes to these inputs have no effect until the next accept.
- States:
  - IDLE. On accept: if D=0, go to PULSE with evrTrigger<=1 and cnt<=W-1. Else go to DELAY with cnt<=D-1.
  - DELAY. cnt!=0: decrement. cnt=0: go to PULSE, evrTrigger<=1, cnt<=W-1, triggerCount+1 (wrap).
  - PULSE. cnt!=0: decrement. cnt=0: evrTrigger<=0, go to IDLE.
  - For D=0 the triggerCount increment happens on the accept cycle.
- Timing: evrTrigger is high for exactly cycles T+1+D .. T+D+W (W ticks). Latency strobe-to-trigger = D+1 ticks.
- busy=1 from T+1 through the last evrTrigger-high cycle. busy returns to 0 in the same cycle evrTrigger falls.
- Strobe while state != IDLE and enable=1: ignored, overrunCount+1, saturating at all-ones. No retrigger and no pulse extension.
- Strobe with widthTicks=0, enable=0, or sync gate failing: ignored, no counter change.
- overrunClear and an overrun in the same cycle: clear wins, overrunCount=0.
- enable=0 in DELAY/PULSE: next cycle state=IDLE, evrTrigger=0. Counters are held (not cleared).
- Reset mid-pulse: evrTrigger=0 on the next cycle; all state returns to reset values.
- Counter width rules: D up to 2^DELAY_WIDTH-1 and W up to 2^WIDTH_WIDTH-1 are legal. The -1 preloads are computed on the latched values. Zero-underflow is impossible because of the D=0 and W=0 guards.
- Back-to-back: a strobe on the first IDLE cycle after the pulse ends is accepted normally.

Decomposition:
- Shared package evr_trigger_pkg holds:
  - state enum {IDLE, DELAY, PULSE}, 2-bit encoding
  - default width constants DELAY_WIDTH=24, WIDTH_WIDTH=16, COUNT_WIDTH=16
- One sub-module: sat_counter (COUNT_WIDTH, inc, clr, sync active-low reset; saturating, clr priority), instantiated for overrunCount.
- triggerCount wrap counter and the FSM stay inline.

Test Plan:
- D=0, W=3: strobe at T → evrTrigger high T+1..T+3; triggerCount=1; busy low at T+4.
- D=5, W=2, requireSync=0: strobe at T → evrTrigger high T+6..T+7. Change delayTicks to 100 at T+2 → pulse still at T+6.
- D=10, W=10: second strobe at T+4 → no extra pulse; overrunCount=1. Strobe at T+21 (first IDLE cycle) → accepted, pulse at T+32..T+41.
- requireSync=1, evrClkGenSynced=0: strobe → no pulse, counters unchanged. Set synced=1 and strobe → pulse.
- widthTicks=0 → no pulse, busy stays 0. Force 70000 overruns with COUNT_WIDTH=16 → overrunCount=65535. overrunClear coincident with an overrun → 0.
- Mid-pulse: deassert enable → evrTrigger=0 next cycle, state IDLE. Separately assert evrReset_n=0 mid-DELAY → all outputs 0 next cycle; no pulse emerges afterward.

Source files
------------

// File: rtl/evr_trigger_pkg.sv
// Shared definitions for the EVR trigger pulse generator.
//   - trig_state_e : FSM state encoding (2 bits)
//   - DEF_*_WIDTH  : default parameter widths used by the top level
package evr_trigger_pkg;

  localparam int DEF_DELAY_WIDTH = 24;
  localparam int DEF_WIDTH_WIDTH = 16;
  localparam int DEF_COUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_PULSE = 2'd2
  } trig_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk_i   : clock
//   rst_ni  : synchronous active-low reset
//   inc_i   : count up by one (holds at all-ones)
//   clr_i   : clear to zero; wins over inc_i
//   count_o : current count
module sat_counter #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   inc_i,
  input  logic                   clr_i,
  output logic [COUNT_WIDTH-1:0] count_o
);

  logic [COUNT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)
      count_d = '0;
    else if (inc_i && (count_q != '1))
      count_d = count_q + COUNT_WIDTH'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/evr_trigger_pulse_gen.sv
// Delayed, width-programmable trigger pulse driven by the EVR generated-clock
// strobe. A qualified strobe in IDLE latches the delay/width; the pulse is
// high for W ticks starting D+1 ticks after the strobe. Strobes arriving
// while busy are dropped and counted as overruns.
// Ports:
//   evrClk, evrReset_n : clock, synchronous active-low reset
//   enable             : block enable; low aborts any activity
//   requireSync        : only accept strobes while evrClkGenSynced=1
//   evrClkGenSynced    : generated clock locked
//   evrClkGenStrobe    : one-tick strobe per generated-clock rising edge
//   delayTicks         : strobe-to-pulse delay (ticks)
//   widthTicks         : pulse width (ticks); 0 suppresses the pulse
//   overrunClear       : one-tick clear of overrunCount
//   evrTrigger         : registered pulse output
//   busy               : FSM not idle
//   triggerCount       : pulses issued (wraps)
//   overrunCount       : strobes dropped while busy (saturates)
module evr_trigger_pulse_gen
  import evr_trigger_pkg::*;
#(
  parameter int DELAY_WIDTH = DEF_DELAY_WIDTH,
  parameter int WIDTH_WIDTH = DEF_WIDTH_WIDTH,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic                   evrClk,
  input  logic                   evrReset_n,
  input  logic                   enable,
  input  logic                   requireSync,
  input  logic                   evrClkGenSynced,
  input  logic                   evrClkGenStrobe,
  input  logic [DELAY_WIDTH-1:0] delayTicks,
  input  logic [WIDTH_WIDTH-1:0] widthTicks,
  input  logic                   overrunClear,
  output logic                   evrTrigger,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] triggerCount,
  output logic [COUNT_WIDTH-1:0] overrunCount
);

  // One shared down-counter serves both the delay and the width phase.
  localparam int CNT_W = (DELAY_WIDTH > WIDTH_WIDTH) ? DELAY_WIDTH : WIDTH_WIDTH;

  trig_state_e            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH_WIDTH-1:0] width_q, width_d;
  logic                   trig_q, trig_d;
  logic [COUNT_WIDTH-1:0] tcnt_q, tcnt_d;
  logic                   trig_inc;

  logic strobe_ok, accept, overrun;

  // A strobe is "qualified" only if it would start a pulse from IDLE; the
  // same qualification decides whether a busy-time strobe is an overrun.
  assign strobe_ok = enable && evrClkGenStrobe &&
                     (!requireSync || evrClkGenSynced) &&
                     (widthTicks != '0);
  assign accept    = (state_q == ST_IDLE) && strobe_ok;
  assign overrun   = (state_q != ST_IDLE) && strobe_ok;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    width_d  = width_q;
    trig_d   = trig_q;
    trig_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          width_d = widthTicks;
          if (delayTicks == '0) begin
            state_d  = ST_PULSE;
            trig_d   = 1'b1;
            trig_inc = 1'b1;
            cnt_d    = CNT_W'(widthTicks - WIDTH_WIDTH'(1));
          end else begin
            state_d = ST_DELAY;
            cnt_d   = CNT_W'(delayTicks - DELAY_WIDTH'(1));
          end
        end
      end
      ST_DELAY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d  = ST_PULSE;
          trig_d   = 1'b1;
          trig_inc = 1'b1;
          cnt_d    = CNT_W'(width_q - WIDTH_WIDTH'(1));
        end
      end
      ST_PULSE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = ST_IDLE;
          trig_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        trig_d  = 1'b0;
      end
    endcase
    // Disable aborts any delay/pulse in progress; counters are untouched.
    if (!enable) begin
      state_d  = ST_IDLE;
      trig_d   = 1'b0;
      trig_inc = 1'b0;
      cnt_d    = '0;
    end
  end

  assign tcnt_d = tcnt_q + COUNT_WIDTH'(trig_inc);

  always_ff @(posedge evrClk) begin
    if (!evrReset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      width_q <= '0;
      trig_q  <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      width_q <= width_d;
      trig_q  <= trig_d;
      tcnt_q  <= tcnt_d;
    end
  end

  sat_counter #(
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_overrun_cnt (
    .clk_i  (evrClk),
    .rst_ni (evrReset_n),
    .inc_i  (overrun),
    .clr_i  (overrunClear),
    .count_o(overrunCount)
  );

  assign evrTrigger   = trig_q;
  assign busy         = (state_q != ST_IDLE);
  assign triggerCount = tcnt_q;

endmodule

// File: tb/tb_evr_trigger_pulse_gen.sv
module tb_evr_trigger_pulse_gen;

  localparam int DW = 24;
  localparam int WW = 16;
  localparam int CW = 16;
  localparam longint CMAX = (64'd1 << CW) - 1;

  logic          evrClk = 1'b0;
  logic          evrReset_n;
  logic          enable;
  logic          requireSync;
  logic          evrClkGenSynced;
  logic          evrClkGenStrobe;
  logic [DW-1:0] delayTicks;
  logic [WW-1:0] widthTicks;
  logic          overrunClear;
  logic          evrTrigger;
  logic          busy;
  logic [CW-1:0] triggerCount;
  logic [CW-1:0] overrunCount;

  evr_trigger_pulse_gen #(
    .DELAY_WIDTH(DW),
    .WIDTH_WIDTH(WW),
    .COUNT_WIDTH(CW)
  ) dut (
    .evrClk         (evrClk),
    .evrReset_n     (evrReset_n),
    .enable         (enable),
    .requireSync    (requireSync),
    .evrClkGenSynced(evrClkGenSynced),
    .evrClkGenStrobe(evrClkGenStrobe),
    .delayTicks     (delayTicks),
    .widthTicks     (widthTicks),
    .overrunClear   (overrunClear),
    .evrTrigger     (evrTrigger),
    .busy           (busy),
    .triggerCount   (triggerCount),
    .overrunCount   (overrunCount)
  );

  always #5 evrClk = ~evrClk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Window model: an accepted strobe books a busy interval and a pulse
  // interval in absolute cycle numbers; abort/reset just shortens it.
  // Cycle e is the cycle following posedge number e.
  longint edge_n  = 0;
  longint b_start = 1;
  longint b_end   = 0;
  longint p_start = 1;
  longint m_tc    = 0;
  longint m_ovr   = 0;
  bit     m_ok;
  bit     m_busy_prev;

  always @(posedge evrClk) begin
    edge_n++;
    m_busy_prev = (edge_n - 1 >= b_start) && (edge_n - 1 <= b_end);
    if (!evrReset_n) begin
      b_start = 1; b_end = 0; p_start = 1; m_tc = 0; m_ovr = 0;
    end else begin
      m_ok = enable && evrClkGenStrobe && (!requireSync || evrClkGenSynced) &&
             (widthTicks != 0);
      if (m_busy_prev && !enable) b_end = edge_n - 1;
      if (overrunClear) m_ovr = 0;
      else if (m_busy_prev && m_ok && m_ovr != CMAX) m_ovr++;
      if (!m_busy_prev && m_ok) begin
        b_start = edge_n;
        p_start = edge_n + longint'(delayTicks);
        b_end   = edge_n - 1 + longint'(delayTicks) + longint'(widthTicks);
      end
      if (p_start == edge_n && edge_n <= b_end) m_tc = (m_tc + 1) & CMAX;
    end
  end

  always @(negedge evrClk) begin
    if (chk_en) begin
      chk("model trig", {31'd0, evrTrigger},
          {31'd0, (edge_n >= p_start) && (edge_n <= b_end)});
      chk("model busy", {31'd0, busy},
          {31'd0, (edge_n >= b_start) && (edge_n <= b_end)});
      chk("model tcnt", {16'd0, triggerCount}, 32'(m_tc));
      chk("model ovr",  {16'd0, overrunCount}, 32'(m_ovr));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge evrClk);
  endtask

  initial begin
    evrReset_n = 0; enable = 0; requireSync = 0; evrClkGenSynced = 0;
    evrClkGenStrobe = 0; delayTicks = '0; widthTicks = '0; overrunClear = 0;
    tick(3);
    chk_en = 1'b1;
    chk("rst trig", {31'd0, evrTrigger}, 0);
    chk("rst busy", {31'd0, busy}, 0);
    chk("rst tcnt", {16'd0, triggerCount}, 0);
    chk("rst ovr",  {16'd0, overrunCount}, 0);
    evrReset_n = 1; enable = 1;
    tick(2);

    // D=0, W=3
    delayTicks = 0; widthTicks = 3; evrClkGenStrobe = 1; tick(1); evrClkGenStrobe = 0;
    chk("d0 trig T+1", {31'd0, evrTrigger}, 1);
    chk("d0 busy T+1", {31'd0, busy}, 1);
    chk("d0 tcnt",     {16'd0, triggerCount}, 1);
    tick(2); chk("d0 trig T+3", {31'd0, evrTrigger}, 1);
    tick(1); chk("d0 trig T+4", {31'd0, evrTrigger}, 0);
    chk("d0 busy T+4", {31'd0, busy}, 0);
    tick(2);

    // D=5, W=2, delay changed mid-flight
    delayTicks = 5; widthTicks = 2; evrClkGenStrobe = 1; tick(1); evrClkGenStrobe = 0;
    tick(1); delayTicks = 100;
    tick(3); chk("d5 trig T+5", {31'd0, evrTrigger}, 0);
    tick(1); chk("d5 trig T+6", {31'd0, evrTrigger}, 1);
    chk("d5 tcnt", {16'd0, triggerCount}, 2);
    tick(1); chk("d5 trig T+7", {31'd0, evrTrigger}, 1);
    tick(1); chk("d5 trig T+8", {31'd0, evrTrigger}, 0);
    chk("d5 busy T+8", {31'd0, busy}, 0);
    tick(2);

    // D=10, W=10, overrun then back-to-back accept
    delayTicks = 10; widthTicks = 10; evrClkGenStrobe = 1; tick(1); evrClkGenStrobe = 0;
    tick(3); evrClkGenStrobe = 1;
    tick(1); evrClkGenStrobe = 0;
    chk("b2b ovr", {16'd0, overrunCount}, 1);
    tick(15); chk("b2b trig T+20", {31'd0, evrTrigger}, 1);
    tick(1); chk("b2b busy T+21", {31'd0, busy}, 0);
    evrClkGenStrobe = 1;
    tick(1); evrClkGenStrobe = 0;
    tick(9); chk("b2b trig T+31", {31'd0, evrTrigger}, 0);
    chk("b2b busy T+31", {31'd0, busy}, 1);
    tick(1); chk("b2b trig T+32", {31'd0, evrTrigger}, 1);
    chk("b2b tcnt", {16'd0, triggerCount}, 4);
    tick(9); chk("b2b trig T+41", {31'd0, evrTrigger}, 1);
    tick(1); chk("b2b trig T+42", {31'd0, evrTrigger}, 0);
    chk("b2b ovr end", {16'd0, overrunCount}, 1);
    tick(2);

    // sync gate
    requireSync = 1; evrClkGenSynced = 0; delayTicks = 2; widthTicks = 2;
    evrClkGenStrobe = 1; tick(1); evrClkGenStrobe = 0;
    for (int i = 0; i < 5; i++) begin
      chk("nosync trig", {31'd0, evrTrigger}, 0);
      chk("nosync busy", {31'd0, busy}, 0);
      tick(1);
    end
    chk("nosync tcnt", {16'd0, triggerCount}, 4);
    evrClkGenSynced = 1;
    evrClkGenStrobe = 1; tick(1); evrClkGenStrobe = 0;
    tick(2); chk("sync trig T+3", {31'd0, evrTrigger}, 1);
    chk("sync tcnt", {16'd0, triggerCount}, 5);
    tick(1); chk("sync trig T+4", {31'd0, evrTrigger}, 1);
    tick(1); chk("sync trig T+5", {31'd0, evrTrigger}, 0);
    requireSync = 0;
    tick(2);

    // width 0 suppressed
    delayTicks = 0; widthTicks = 0; evrClkGenStrobe = 1; tick(1); evrClkGenStrobe = 0;
    chk("w0 busy", {31'd0, busy}, 0);
    chk("w0 trig", {31'd0, evrTrigger}, 0);
    chk("w0 tcnt", {16'd0, triggerCount}, 5);
    tick(2);

    // overrun saturation, clear priority, abort in DELAY
    delayTicks = 24'd70000; widthTicks = 1; evrClkGenStrobe = 1;
    tick(66000);
    chk("sat ovr",  {16'd0, overrunCount}, 65535);
    chk("sat busy", {31'd0, busy}, 1);
    overrunClear = 1; tick(1); overrunClear = 0;
    chk("clr ovr", {16'd0, overrunCount}, 0);
    tick(1); chk("clr ovr +1", {16'd0, overrunCount}, 1);
    evrClkGenStrobe = 0; enable = 0;
    tick(1); chk("abort busy", {31'd0, busy}, 0);
    chk("abort ovr hold", {16'd0, overrunCount}, 1);
    enable = 1;
    tick(2);

    // enable drop mid-pulse
    delayTicks = 1; widthTicks = 8; evrClkGenStrobe = 1; tick(1); evrClkGenStrobe = 0;
    tick(3); chk("en trig T+4", {31'd0, evrTrigger}, 1);
    enable = 0;
    tick(1); chk("en trig off", {31'd0, evrTrigger}, 0);
    chk("en busy off", {31'd0, busy}, 0);
    chk("en tcnt hold", {16'd0, triggerCount}, 6);
    enable = 1;
    tick(2);

    // reset mid-DELAY
    delayTicks = 20; widthTicks = 4; evrClkGenStrobe = 1; tick(1); evrClkGenStrobe = 0;
    tick(2); chk("rd busy", {31'd0, busy}, 1);
    evrReset_n = 0;
    tick(1);
    chk("rd trig", {31'd0, evrTrigger}, 0);
    chk("rd busy0", {31'd0, busy}, 0);
    chk("rd tcnt", {16'd0, triggerCount}, 0);
    chk("rd ovr",  {16'd0, overrunCount}, 0);
    evrReset_n = 1;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      chk("rd no pulse", {31'd0, evrTrigger}, 0);
    end
    tick(2);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
